// File: rtl/mem_responder_if.sv
// Protocol bundle between the test initiator (master) and mem_responder (slave).
// Parity signals exist only when MEM_PARITY_EN is defined.
interface mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              ready;
    logic              proto_err;
    logic [7:0]        err_cnt;
`ifdef MEM_PARITY_EN
    logic              par_inj;
    logic              parity_err;

    modport master (
        output read, write, addr, data_in, par_inj,
        input  data_out, ready, proto_err, err_cnt, parity_err
    );

    modport slave (
        input  read, write, addr, data_in, par_inj,
        output data_out, ready, proto_err, err_cnt, parity_err
    );
`else
    modport master (
        output read, write, addr, data_in,
        input  data_out, ready, proto_err, err_cnt
    );

    modport slave (
        input  read, write, addr, data_in,
        output data_out, ready, proto_err, err_cnt
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// 32x8 synchronous test memory with a post-reset clear sweep, registered reads and
// illegal-command counting. Define MEM_PARITY_EN to add a stored even-parity bit per word.
module mem_responder #(
    parameter int               DATA_W    = 8,
    parameter int               ADDR_W    = 5,
    parameter logic [DATA_W-1:0] CLEAR_VAL = 8'h00
) (
    input logic            clk,
    input logic            rst,
    mem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [MEM_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0] data_out_q;
    logic              ready_q;
    logic              proto_err_q;
    logic [7:0]        err_cnt_q;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  clear_word;
    logic [MEM_W-1:0]  wr_word;

    assign rd_word = mem[bus.addr];

`ifdef MEM_PARITY_EN
    logic parity_err_q;

    assign clear_word     = {^CLEAR_VAL, CLEAR_VAL};
    assign wr_word        = {(^bus.data_in) ^ bus.par_inj, bus.data_in};
    assign bus.parity_err = parity_err_q;
`else
    assign clear_word = CLEAR_VAL;
    assign wr_word    = bus.data_in;
`endif

    assign bus.data_out  = data_out_q;
    assign bus.ready     = ready_q;
    assign bus.proto_err = proto_err_q;
    assign bus.err_cnt   = err_cnt_q;

    // Commands are only decoded once ready is visible, so the first RUN cycle just raises ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            ptr         <= '0;
            data_out_q  <= '0;
            ready_q     <= 1'b0;
            proto_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
`ifdef MEM_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                CLEAR: begin
                    mem[ptr] <= clear_word;
                    ptr      <= ptr + 1'b1;
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (bus.read && bus.write) begin
                        proto_err_q <= 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
                    end else if (bus.read) begin
                        data_out_q <= rd_word[DATA_W-1:0];
`ifdef MEM_PARITY_EN
                        parity_err_q <= ^rd_word;
`endif
                    end else if (bus.write) begin
                        mem[bus.addr] <= wr_word;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
